// File: rtl/fir_mac_serial_pkg.sv
// fir_mac_serial_pkg
//   Shared definitions for the serial FIR MAC core: FSM state encoding,
//   default widths and the output saturation helper.
package fir_mac_serial_pkg;

  localparam int unsigned DEF_COUNTER_BITS   = 6;
  localparam int unsigned DEF_NUMBER_OF_TAPS = 64;
  localparam int unsigned DEF_COEFF_BITS     = 16;
  localparam int unsigned DEF_DATA_BITS      = 16;
  localparam int unsigned DEF_ACC_BITS       = DEF_DATA_BITS + DEF_COEFF_BITS + DEF_COUNTER_BITS;

  // Working width of the saturation helper; callers sign-extend into it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  // Clamp a signed value to the range of a signed 'bits'-wide integer.
  // The result is still SAT_W wide; the caller truncates to 'bits'.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             bits
  );
    logic [SAT_W-1:0]        ones;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    ones  = '1;
    max_v = $signed(ones >> (SAT_W - bits + 1));
    min_v = ~max_v;
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/fir_mac_serial_sample_history_ram.sv
// sample_history_ram
//   Circular sample history for the FIR core: DEPTH x DATA_BITS register
//   array, one synchronous write port, one combinational read port, and an
//   asynchronous clear of every entry.
// Ports:
//   clk, rst_n   clock / asynchronous active-low clear
//   wr_en        write wr_data at wr_addr on the rising edge
//   wr_addr      write index
//   wr_data      sample to store
//   rd_addr      read index
//   rd_data      combinational read of entry rd_addr
module sample_history_ram
  import fir_mac_serial_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_COUNTER_BITS,
  parameter int unsigned DEPTH     = DEF_NUMBER_OF_TAPS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic signed [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]        rd_addr,
  output logic signed [DATA_BITS-1:0] rd_data
);

  logic signed [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_mac_serial.sv
// fir_mac_serial
//   Time-multiplexed FIR multiply-accumulate core. Each accepted sample is
//   written into a circular history and then NUMBER_OF_TAPS MAC cycles sweep
//   the taps, newest sample against coefficient 0. The result is shifted back
//   from Q1.(COEFF_BITS-1), saturated to DATA_BITS and presented with a
//   one-cycle out_valid pulse.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   in_valid       input sample offered
//   in_sample      signed input sample
//   in_ready       high while idle; sample accepted on in_valid && in_ready
//   current_count  tap index driven to the external coefficient mux
//   coeff          signed coefficient for current_count (same-cycle return)
//   out_valid      one-cycle pulse when out_sample updates
//   out_sample     signed filtered sample, held until the next result
//   busy           high during a MAC sweep
module fir_mac_serial
  import fir_mac_serial_pkg::*;
#(
  parameter int unsigned COUNTER_BITS   = DEF_COUNTER_BITS,
  parameter int unsigned NUMBER_OF_TAPS = DEF_NUMBER_OF_TAPS,
  parameter int unsigned COEFF_BITS     = DEF_COEFF_BITS,
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter int unsigned ACC_BITS       = DATA_BITS + COEFF_BITS + COUNTER_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_BITS-1:0]  in_sample,
  output logic                         in_ready,
  output logic [COUNTER_BITS-1:0]      current_count,
  input  logic signed [COEFF_BITS-1:0] coeff,
  output logic                         out_valid,
  output logic signed [DATA_BITS-1:0]  out_sample,
  output logic                         busy
);

  localparam int unsigned PROD_BITS = DATA_BITS + COEFF_BITS;

  state_t state;
  state_t state_next;

  logic [COUNTER_BITS-1:0]       count;
  logic [COUNTER_BITS-1:0]       wr_ptr;
  logic [COUNTER_BITS-1:0]       base;
  logic [COUNTER_BITS-1:0]       rd_addr;
  logic signed [DATA_BITS-1:0]   hist_rd;
  logic signed [PROD_BITS-1:0]   prod;
  logic signed [ACC_BITS-1:0]    prod_ext;
  logic signed [ACC_BITS-1:0]    acc;
  logic signed [ACC_BITS-1:0]    acc_sum;
  logic signed [ACC_BITS-1:0]    shifted;
  logic signed [SAT_W-1:0]       sat_in;
  logic signed [DATA_BITS-1:0]   out_next;
  logic                          accept;
  logic                          last_tap;

  assign accept   = in_valid && (state == ST_IDLE);
  assign last_tap = (count == COUNTER_BITS'(NUMBER_OF_TAPS - 1));

  // Tap k pairs coefficient k with the sample k steps older than the newest;
  // the subtraction wraps naturally because the history depth is 2**COUNTER_BITS.
  assign rd_addr = base - count;

  sample_history_ram #(
    .ADDR_BITS (COUNTER_BITS),
    .DEPTH     (NUMBER_OF_TAPS),
    .DATA_BITS (DATA_BITS)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (in_sample),
    .rd_addr (rd_addr),
    .rd_data (hist_rd)
  );

  assign prod     = coeff * hist_rd;
  assign prod_ext = $signed({{(ACC_BITS - PROD_BITS){prod[PROD_BITS-1]}}, prod});
  assign acc_sum  = acc + prod_ext;

  // Final tap folds its product in combinationally so the result registers
  // on the same edge that ends the sweep.
  assign shifted  = acc_sum >>> (COEFF_BITS - 1);
  assign sat_in   = $signed({{(SAT_W - ACC_BITS){shifted[ACC_BITS-1]}}, shifted});
  assign out_next = DATA_BITS'(saturate(sat_in, DATA_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    busy          = 1'b0;
    current_count = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = ST_MAC;
      end
      ST_MAC: begin
        busy          = 1'b1;
        current_count = count;
        if (last_tap) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      base       <= '0;
      count      <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        base   <= wr_ptr;
        wr_ptr <= wr_ptr + 1'b1;
        acc    <= '0;
        count  <= '0;
      end else if (state == ST_MAC) begin
        acc   <= acc_sum;
        count <= count + 1'b1;
        if (last_tap) begin
          out_sample <= out_next;
          out_valid  <= 1'b1;
        end
      end
    end
  end

endmodule
